// File: rtl/md_bus_master.sv
// ---------------------------------------------------------------------------
// md_bus_master
// Console-side initiator for the Mega Drive cartridge bus. It turns a
// single-word read or write request into a phased cartridge cycle
// (SETUP -> STROBE -> HOLD -> DONE) and returns the read data.
//
// Ports
//   clk           system clock, all state on the rising edge
//   vres          asynchronous active-low reset
//   req_valid     request present
//   req_ready     high only in IDLE; accept = req_valid & req_ready
//   req_write     1 = write, 0 = read
//   req_addr      word address [23:1]
//   req_wdata     write data
//   rsp_valid     one-cycle completion pulse
//   rsp_rdata     read data ($FFFF when unmapped), held until the next read completes
//   rsp_err       1 = unmapped address, no bus cycle was run
//   cart_address  bus address [23:1]
//   cart_data     bidirectional bus data, driven only during write cycles
//   ce_0          active-low ROM/SRAM select
//   tme           active-low $A130xx select
//   cas0          0 = read strobe
//   lwr           active-low lower-byte write strobe
// ---------------------------------------------------------------------------
module md_bus_master #(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned STROBE_CYCLES = 3,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        vres,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [22:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [22:0] cart_address,
  inout  wire  [15:0] cart_data,
  output logic        ce_0,
  output logic        tme,
  output logic        cas0,
  output logic        lwr
);

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CNT_W-1:0] SETUP_N  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_N = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_N   = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    R_NONE,
    R_CE,
    R_TIME
  } region_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    region_e           region;
  } req_t;

  // Region decode on the byte address {addr, 1'b0}
  function automatic region_e decode(input logic [ADDR_W-1:0] a);
    region_e r;
    r = R_NONE;
    if (a[22:21] == 2'b00) begin
      r = R_CE;                     // byte address below $400000
    end else if (a[22:7] == 16'hA130) begin
      r = R_TIME;                   // byte address $A130xx
    end
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  req_t               req_q, req_d;
  logic [DATA_W-1:0]  cap_q, cap_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               ce_q, ce_d;
  logic               tme_q, tme_d;
  logic               cas_q, cas_d;
  logic               lwr_q, lwr_d;
  logic               oe_q, oe_d;

  logic               bus_phase;
  logic               mapped;

  // Next-state, request latch and response logic; pin values follow the
  // next state so every pin is a flop output that changes with the state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    cap_d       = cap_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    addr_d      = addr_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_d   = '{write: req_write, addr: req_addr, wdata: req_wdata,
                      region: decode(req_addr)};
          state_d = S_SETUP;
          cnt_d   = SETUP_N;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_N;
        end else begin
          cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          // Last strobe cycle: cas0 is still low on this edge
          cap_d   = (req_q.region == R_NONE) ? {DATA_W{1'b1}} : cart_data;
          state_d = S_HOLD;
          cnt_d   = HOLD_N;
        end else begin
          cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          err_d   = (req_q.region == R_NONE);
          if (!req_q.write) begin
            rdata_d = cap_q;
          end
        end else begin
          cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    bus_phase   = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    mapped      = (req_d.region != R_NONE);

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_DONE);

    if (state_d == S_SETUP) begin
      addr_d = req_d.addr;
    end
    ce_d  = !(bus_phase && (req_d.region == R_CE));
    tme_d = !(bus_phase && (req_d.region == R_TIME));
    cas_d = !((state_d == S_STROBE) && mapped && !req_d.write);
    lwr_d = !((state_d == S_STROBE) && mapped && req_d.write);
    oe_d  = bus_phase && mapped && req_d.write;
  end

  // State and output registers
  always_ff @(posedge clk or negedge vres) begin
    if (!vres) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_q       <= '{write: 1'b0, addr: '0, wdata: '0, region: R_NONE};
      cap_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      ce_q        <= 1'b1;
      tme_q       <= 1'b1;
      cas_q       <= 1'b1;
      lwr_q       <= 1'b1;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      cap_q       <= cap_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      ce_q        <= ce_d;
      tme_q       <= tme_d;
      cas_q       <= cas_d;
      lwr_q       <= lwr_d;
      oe_q        <= oe_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;
  assign cart_address = addr_q;
  assign ce_0         = ce_q;
  assign tme          = tme_q;
  assign cas0         = cas_q;
  assign lwr          = lwr_q;

  // Write data stays on the bus from SETUP through HOLD
  assign cart_data = oe_q ? req_q.wdata : {DATA_W{1'bz}};

endmodule
